// File: rtl/bht_predictor.sv
// Branch history table: a direct-mapped array of saturating up/down counters
// read by fetch (predict port) and trained by execute (update port).
`timescale 1ns/1ps

// Per-entry counter (2-bit case), taken moves right, not-taken moves left:
//   state | meaning
//   00    | strongly not taken (self-loop on not-taken)
//   01    | weakly not taken (reset value)
//   10    | weakly taken
//   11    | strongly taken (self-loop on taken)
module bht_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  predict_req,
    input  logic [XLEN-1:0]       predict_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  update_valid,
    input  logic [XLEN-1:0]       update_pc,
    input  logic                  update_taken,
    output logic [15:0]           mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_MIN  = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};

    logic [CTR_WIDTH-1:0]  ctr_table [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_WIDTH-1:0]  upd_cur;
    logic [CTR_WIDTH-1:0]  upd_next;
    logic [CTR_WIDTH-1:0]  pred_ctr;
    logic                  upd_mispredict;
    logic                  unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never select an entry, and there are no tags.
    assign pred_idx = predict_pc[INDEX_BITS+1:2];
    assign upd_idx  = update_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{predict_pc[XLEN-1:INDEX_BITS+2], predict_pc[1:0],
                              update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0]};

    assign upd_cur        = ctr_table[upd_idx];
    assign upd_mispredict = upd_cur[CTR_WIDTH-1] != update_taken;

    always_comb begin
        upd_next = upd_cur;
        if (update_taken && upd_cur != CTR_MAX)
            upd_next = upd_cur + CTR_ONE;
        else if (!update_taken && upd_cur != CTR_MIN)
            upd_next = upd_cur - CTR_ONE;
    end

    // Write-first: a same-cycle update to the predicted entry is visible to fetch.
    assign pred_ctr = (update_valid && upd_idx == pred_idx) ? upd_next : ctr_table[pred_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_table[i] <= CTR_INIT;
            predict_valid    <= 1'b0;
            predict_taken    <= 1'b0;
            predict_index    <= '0;
            mispredict_count <= 16'd0;
        end else begin
            if (update_valid) begin
                ctr_table[upd_idx] <= upd_next;
                if (upd_mispredict && mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
            end
            predict_valid <= predict_req;
            if (predict_req) begin
                predict_taken <= pred_ctr[CTR_WIDTH-1];
                predict_index <= pred_idx;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: a behavioural table model checked every
// cycle, plus literal expectations that pin the model to the intended behaviour.
`timescale 1ns/1ps

module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        predict_req = 1'b0;
    logic [31:0] predict_pc = 32'd0;
    logic        predict_valid;
    logic        predict_taken;
    logic [5:0]  predict_index;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = 32'd0;
    logic        update_taken = 1'b0;
    logic [15:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: plain integers, counters range 0..3, taken when >= 2
    int   mctr [64];
    int   mmis = 0;
    logic exp_valid = 1'b0;
    logic exp_taken = 1'b0;
    int   exp_index = 0;

    bht_predictor #(.INDEX_BITS(6), .CTR_WIDTH(2), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .predict_req      (predict_req),
        .predict_pc       (predict_pc),
        .predict_valid    (predict_valid),
        .predict_taken    (predict_taken),
        .predict_index    (predict_index),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mctr[i] = 1;
            mmis      = 0;
            exp_valid = 1'b0;
            exp_taken = 1'b0;
            exp_index = 0;
        end else begin
            if (update_valid) begin
                int ui;
                ui = int'((update_pc >> 2) % 64);
                if ((mctr[ui] >= 2) != update_taken && mmis < 65535) mmis++;
                if (update_taken) mctr[ui] = (mctr[ui] < 3) ? mctr[ui] + 1 : 3;
                else              mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
            end
            exp_valid = predict_req;
            if (predict_req) begin
                exp_index = int'((predict_pc >> 2) % 64);
                exp_taken = (mctr[exp_index] >= 2);
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", {31'd0, predict_valid}, {31'd0, exp_valid});
        chk("taken", {31'd0, predict_taken}, {31'd0, exp_taken});
        chk("index", {26'd0, predict_index}, exp_index);
        chk("mispredicts", {16'd0, mispredict_count}, mmis);
    end

    task automatic cyc(input logic preq, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc, input logic ut);
        predict_req  = preq;
        predict_pc   = ppc;
        update_valid = uv;
        update_pc    = upc;
        update_taken = ut;
        @(posedge clk);
        @(negedge clk);
        predict_req  = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic pred(input logic [31:0] ppc);
        cyc(1'b1, ppc, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic ut);
        cyc(1'b0, 32'd0, 1'b1, upc, ut);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        chk("reset valid", {31'd0, predict_valid}, 32'd0);
        chk("reset count", {16'd0, mispredict_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        pred(32'h100);
        chk("first valid", {31'd0, predict_valid}, 32'd1);
        chk("first taken", {31'd0, predict_taken}, 32'd0);
        chk("first index", {26'd0, predict_index}, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("idle valid", {31'd0, predict_valid}, 32'd0);

        upd(32'h104, 1'b1);
        pred(32'h104);
        chk("train taken 1", {31'd0, predict_taken}, 32'd1);
        chk("train index", {26'd0, predict_index}, 32'd1);
        upd(32'h104, 1'b1);
        upd(32'h104, 1'b1);
        upd(32'h104, 1'b1);
        pred(32'h104);
        chk("sat high taken", {31'd0, predict_taken}, 32'd1);
        chk("count after train", {16'd0, mispredict_count}, 32'd1);

        upd(32'h104, 1'b0);
        upd(32'h104, 1'b0);
        pred(32'h104);
        chk("untrain taken", {31'd0, predict_taken}, 32'd0);
        chk("count after untrain", {16'd0, mispredict_count}, 32'd3);
        for (int k = 0; k < 3; k++) upd(32'h104, 1'b0);
        upd(32'h104, 1'b1);
        pred(32'h104);
        chk("no wrap low", {31'd0, predict_taken}, 32'd0);
        chk("count after low", {16'd0, mispredict_count}, 32'd4);

        cyc(1'b1, 32'h108, 1'b1, 32'h108, 1'b1);
        chk("bypass same idx", {31'd0, predict_taken}, 32'd1);
        cyc(1'b1, 32'h110, 1'b1, 32'h10C, 1'b1);
        chk("diff idx", {31'd0, predict_taken}, 32'd0);
        chk("diff idx index", {26'd0, predict_index}, 32'd4);

        upd(32'h000, 1'b1);
        upd(32'h000, 1'b1);
        pred(32'h100);
        chk("alias taken", {31'd0, predict_taken}, 32'd1);
        chk("count before reset", {16'd0, mispredict_count}, 32'd7);

        upd(32'h004, 1'b1);
        upd(32'h004, 1'b1);
        predict_req = 1'b1;
        predict_pc  = 32'h004;
        @(posedge clk);
        #2;
        chk("pre-reset taken", {31'd0, predict_taken}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async valid", {31'd0, predict_valid}, 32'd0);
        chk("async taken", {31'd0, predict_taken}, 32'd0);
        chk("async index", {26'd0, predict_index}, 32'd0);
        chk("async count", {16'd0, mispredict_count}, 32'd0);
        @(negedge clk);
        predict_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pred(32'h004);
        chk("post reset valid", {31'd0, predict_valid}, 32'd1);
        chk("post reset taken", {31'd0, predict_taken}, 32'd0);
        chk("post reset count", {16'd0, mispredict_count}, 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
